dmem_ctrl: RTL

Multi-cycle data-memory controller that sits directly downstream of the EX stage. It takes the ALU address, the store data and the memory control signals, then runs a request/acknowledge transaction on an external data bus. It returns sign- or zero-extended load data to WB and stalls the core until the access completes. It also performs byte-lane steering, alignment checking and a bus timeout.

---
 rtl/dmem_ctrl_if.sv | 23 ++
 rtl/dmem_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// External data-bus bundle between the data-memory controller and the memory system.
// The controller uses the master modport; the memory side uses the slave modport.
interface dmem_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             bus_req;
  logic             bus_we;
  logic [WIDTH-1:0] bus_addr;
  logic [3:0]       bus_be;
  logic [WIDTH-1:0] bus_wdata;
  logic             bus_ack;
  logic [WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: lane steering, alignment check, req/ack bus
// transaction with timeout, and sign/zero-extended load return with core stall.
module dmem_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] data_write,
  output logic [WIDTH-1:0] data_read,
  output logic             stall,
  output logic             misaligned,
  output logic             bus_err,
  dmem_ctrl_if.master      bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [7:0]       count;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;

  logic             op;
  logic             is_byte;
  logic             is_half;
  logic             aligned;
  logic [3:0]       be_next;
  logic [WIDTH-1:0] wdata_next;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [WIDTH-1:0] load_val;

  always_comb begin
    op      = mem_read | mem_write;
    is_byte = (funct3[1:0] == 2'b00);
    is_half = (funct3[1:0] == 2'b01);
    aligned = is_byte | (is_half & ~address[0]) |
              (~is_byte & ~is_half & (address[1:0] == 2'b00));

    if (is_byte) begin
      be_next    = 4'b0001 << address[1:0];
      wdata_next = {4{data_write[7:0]}};
    end else if (is_half) begin
      be_next    = 4'b0011 << address[1:0];
      wdata_next = {2{data_write[15:0]}};
    end else begin
      be_next    = 4'b1111;
      wdata_next = data_write;
    end

    stall = ((state == IDLE) & op & aligned) | (state == REQ);
  end

  // Extraction works on the live bus word so the result registers on the ack edge.
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = bus.bus_rdata[7:0];
      2'd1:    rd_byte = bus.bus_rdata[15:8];
      2'd2:    rd_byte = bus.bus_rdata[23:16];
      default: rd_byte = bus.bus_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_val = {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{~f3_q[2] & rd_half[15]}}, rd_half};
      default: load_val = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      f3_q          <= '0;
      lane_q        <= '0;
      data_read     <= '0;
      misaligned    <= 1'b0;
      bus_err       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (op && aligned) begin
            bus.bus_we    <= mem_write;
            bus.bus_addr  <= {address[WIDTH-1:2], 2'b00};
            bus.bus_be    <= be_next;
            bus.bus_wdata <= wdata_next;
            bus.bus_req   <= 1'b1;
            f3_q          <= funct3;
            lane_q        <= address[1:0];
            count         <= '0;
            state         <= REQ;
          end else if (op) begin
            misaligned <= 1'b1;
            data_read  <= '0;
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) data_read <= load_val;
            state <= DONE;
          end else if (count == 8'(TIMEOUT - 1)) begin
            bus.bus_req <= 1'b0;
            bus_err     <= 1'b1;
            data_read   <= '0;
            state       <= DONE;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
